mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: AW, default 32, address width.
REQ-002 Parameter: DW, default 32, data width.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 req0 / req1  in  1  request from requester 0 (fetch) / 1 (load-store).
REQ-007 addr0 / addr1  in  AW  request address per requester.
REQ-008 wdata0 / wdata1  in  DW  write data per requester.
REQ-009 we0 / we1  in  1  write enable per requester.
REQ-010 gnt0 / gnt1  out  1  one-cycle pulse: requester's transaction accepted by memory.
REQ-011 done0 / done1  out  1  one-cycle pulse: transaction complete; rdata valid this cycle.
REQ-012 rdata  out  DW  read data, shared by both requesters.
REQ-013 mem_valid  out  1  shared-port request strobe.
REQ-014 mem_addr / mem_wdata / mem_we  out  AW / DW / 1  shared-port command.
REQ-015 mem_ready  in  1  memory accepts the command and returns mem_rdata in the same cycle.
REQ-016 mem_rdata  in  DW  memory read data.

Function
REQ-017 FSM states SHALL be IDLE, BUSY0, BUSY1.
- IDLE -> BUSYn when the winning reqn = 1.
- BUSYn -> IDLE on mem_ready.
REQ-018 Arbitration SHALL be round-robin.
- Single pointer last_gnt, reset 1, so requester 0 wins first.
- On simultaneous req0 and req1 in IDLE, the requester not equal to last_gnt SHALL win.
REQ-019 On entering BUSYn:
- Address, wdata and we of requester n SHALL be registered into the command register.
- A 1-bit select register SHALL equal n.
- mem_addr, mem_wdata and mem_we SHALL be driven from the command register.
REQ-020 mem_valid SHALL be 1 in BUSY0/BUSY1 and 0 in IDLE.
- Latency: request to mem_valid = 1 cycle.
REQ-021 Handshake: mem_valid and command SHALL hold stable until mem_ready = 1. Requesters SHALL hold reqn, addrn, wdatan and wen stable until donen.
REQ-022 On the mem_ready cycle in BUSYn:
- gntn and donen SHALL pulse for that one cycle.
- rdata SHALL be registered from mem_rdata and valid in the same cycle as donen.
- last_gnt SHALL be set to n.
REQ-023 A granted requester SHALL NOT be preempted. A request arriving while BUSY SHALL wait; it is served no earlier than the cycle after return to IDLE.
REQ-024 The FSM SHALL always return to IDLE for one cycle between transactions, so back-to-back service costs 2 cycles minimum per transaction.
REQ-025 Deassertion of reqn in IDLE before selection SHALL leave no side effect.
REQ-026 gnt0&gnt1 and done0&done1 SHALL never be 1 simultaneously.
REQ-027 rdata SHALL hold its last value outside done pulses.
REQ-028 mem_we SHALL be 0 whenever mem_valid = 0.

Reset
REQ-029 Reset SHALL override all other inputs and set:
- state = IDLE, last_gnt = 1, select = 0.
- mem_valid, mem_we, gnt0, gnt1, done0, done1 = 0.
- mem_addr, mem_wdata, rdata = 0.
REQ-030 Reset mid-transaction SHALL abandon the transaction with no done pulse. The first post-reset arbitration SHALL follow REQ-018.

Configuration
REQ-031 Macro MEM_PORT_ARBITER_FIXED_PRIO_EN:
- Defined: requester 0 SHALL always win simultaneous requests, and last_gnt SHALL be unused.
- Undefined: round-robin per REQ-018.
All other behaviour SHALL be identical in both builds.

Structure
REQ-032 State encodings (IDLE=2'd0, BUSY0=2'd1, BUSY1=2'd2) and requester IDs SHALL live in a shared header/package, mem_arb_defs, reused by the core top.
REQ-033 Address and data steering SHALL instantiate the existing 32-bit 2:1 mux sub-module, mux2_1, driven by the registered select. No other sub-module SHALL be used.

Verification
REQ-034 Single read: req0 = 1, addr0 = 0x0000_0040, mem_ready at the 2nd BUSY cycle, mem_rdata = 0xDEAD_BEEF -> mem_valid 1 cycle after req0; done0 pulse; rdata = 0xDEAD_BEEF.
REQ-035 Contention: req0 = req1 = 1 held from reset, mem_ready = 1 always -> grants alternate 0,1,0,1 with an IDLE cycle between each (round-robin build); all grants go to 0 with FIXED_PRIO_EN defined.
REQ-036 Write: req1 = 1, we1 = 1, addr1 = 0x100, wdata1 = 0x1234_5678 -> mem_we = 1, mem_addr = 0x100, mem_wdata = 0x1234_5678, held stable while mem_ready = 0 for 3 cycles; done1 pulses once.
REQ-037 No preemption: req1 asserted while BUSY0 waits 4 cycles -> no gnt1 until after done0 plus one IDLE cycle; mem_addr unchanged throughout BUSY0.
REQ-038 Reset mid-operation: reset asserted in BUSY1 -> next cycle mem_valid = 0, no done1 pulse, state IDLE. Then req0 = req1 = 1 -> requester 0 granted first.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_defs: shared definitions for the memory port arbiter.
//   state_t   : arbiter FSM state encoding (IDLE / BUSY0 / BUSY1)
//   REQ_FETCH : requester id 0 (instruction fetch)
//   REQ_LDST  : requester id 1 (load-store)
package mem_arb_defs;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY0 = 2'd1,
      BUSY1 = 2'd2
   } state_t;

   localparam logic REQ_FETCH = 1'b0;
   localparam logic REQ_LDST  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and shared-memory signals of the arbiter.
//   Requester side : req0/1, addr0/1, wdata0/1, we0/1 in; gnt0/1, done0/1, rdata out
//   Memory side    : mem_valid, mem_addr, mem_wdata, mem_we out; mem_ready, mem_rdata in
//   modport slave  : the arbiter's view
//   modport master : the environment's view (requesters + memory)
interface mem_port_arbiter_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   logic          req0;
   logic          req1;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata0;
   logic [DW-1:0] wdata1;
   logic          we0;
   logic          we1;
   logic          gnt0;
   logic          gnt1;
   logic          done0;
   logic          done1;
   logic [DW-1:0] rdata;
   logic          mem_valid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic          mem_ready;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1,
      input  mem_ready, mem_rdata,
      output gnt0, gnt1, done0, done1, rdata,
      output mem_valid, mem_addr, mem_wdata, mem_we
   );

   modport master (
      output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1,
      output mem_ready, mem_rdata,
      input  gnt0, gnt1, done0, done1, rdata,
      input  mem_valid, mem_addr, mem_wdata, mem_we
   );

endinterface

// File: rtl/mem_port_arbiter_mux2_1.sv
// mux2_1: W-bit 2:1 multiplexer (default 32 bits).
//   sel : 0 selects in0, 1 selects in1
//   in0, in1 : data inputs; out : selected data
module mux2_1 #(
   parameter int unsigned W = 32
) (
   input  logic         sel,
   input  logic [W-1:0] in0,
   input  logic [W-1:0] in1,
   output logic [W-1:0] out
);

   assign out = sel ? in1 : in0;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between a fetch requester (0)
// and a load-store requester (1). Round-robin arbitration by default;
// define MEM_PORT_ARBITER_FIXED_PRIO_EN to make requester 0 always win ties.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : mem_port_arbiter_if.slave (requester + memory signals)
// gnt/done pulse in the cycle the memory asserts mem_ready; rdata shows
// mem_rdata during that cycle and holds the captured value afterwards.
import mem_arb_defs::*;

module mem_port_arbiter #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) (
   input  logic                clk,
   input  logic                reset,
   mem_port_arbiter_if.slave   bus
);

   state_t        state;
   logic          sel_q;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          cmd_we;
   logic [DW-1:0] rdata_q;
   logic          win;
   logic          ready_hit;
   logic [AW+DW:0] cmd_next;

`ifndef MEM_PORT_ARBITER_FIXED_PRIO_EN
   logic          last_gnt;
`endif

   // Winner of the current IDLE cycle; this is the value loaded into sel_q.
   always_comb begin
      win = REQ_LDST;
`ifdef MEM_PORT_ARBITER_FIXED_PRIO_EN
      if (bus.req0) win = REQ_FETCH;
`else
      if (bus.req0 && bus.req1) win = ~last_gnt;
      else if (bus.req0)        win = REQ_FETCH;
`endif
   end

   // Steers the winning requester's command into the command register.
   mux2_1 #(.W(AW + DW + 1)) u_cmd_mux (
      .sel (win),
      .in0 ({bus.addr0, bus.wdata0, bus.we0}),
      .in1 ({bus.addr1, bus.wdata1, bus.we1}),
      .out (cmd_next)
   );

   // Completion is suppressed while reset is high so an abandoned
   // transaction can never produce a done pulse.
   assign ready_hit = !reset && (state != IDLE) && bus.mem_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         sel_q     <= REQ_FETCH;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
         cmd_we    <= 1'b0;
         rdata_q   <= '0;
`ifndef MEM_PORT_ARBITER_FIXED_PRIO_EN
         last_gnt  <= REQ_LDST;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.req0 || bus.req1) begin
                  state <= (win == REQ_LDST) ? BUSY1 : BUSY0;
                  sel_q <= win;
                  {cmd_addr, cmd_wdata, cmd_we} <= cmd_next;
               end
            end
            BUSY0, BUSY1: begin
               if (bus.mem_ready) begin
                  state   <= IDLE;
                  cmd_we  <= 1'b0;
                  rdata_q <= bus.mem_rdata;
`ifndef MEM_PORT_ARBITER_FIXED_PRIO_EN
                  last_gnt <= sel_q;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.mem_valid = (state != IDLE);
   assign bus.mem_addr  = cmd_addr;
   assign bus.mem_wdata = cmd_wdata;
   assign bus.mem_we    = cmd_we;
   assign bus.gnt0      = ready_hit && (sel_q == REQ_FETCH);
   assign bus.gnt1      = ready_hit && (sel_q == REQ_LDST);
   assign bus.done0     = ready_hit && (sel_q == REQ_FETCH);
   assign bus.done1     = ready_hit && (sel_q == REQ_LDST);
   assign bus.rdata     = ready_hit ? bus.mem_rdata : rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.
// Define MEM_PORT_ARBITER_FIXED_PRIO_EN for both RTL and bench to check
// the fixed-priority build.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   int   cyc = 0;
   int   done0_cnt = 0;
   int   done1_cnt = 0;
   int   gnt_id[$];
   int   gnt_cyc[$];

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

   mem_port_arbiter #(.AW(32), .DW(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Grant/done logging and mutual-exclusion check, sampled mid-cycle.
   always @(negedge clk) begin
      cyc++;
      if (bus.done0) done0_cnt++;
      if (bus.done1) done1_cnt++;
      if (bus.gnt0) begin gnt_id.push_back(0); gnt_cyc.push_back(cyc); end
      if (bus.gnt1) begin gnt_id.push_back(1); gnt_cyc.push_back(cyc); end
      checks++;
      if ((bus.gnt0 && bus.gnt1) || (bus.done0 && bus.done1)) begin
         errors++;
         $display("FAIL exclusive: gnt=%b%b done=%b%b required no overlap",
                  bus.gnt0, bus.gnt1, bus.done0, bus.done1);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'hFFFF_FFFF;
      bus.req0 = 1'b1;
      tick();
      tick();
      checks++;
      if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.mem_valid); end
      checks++;
      if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", bus.mem_we); end
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1} !== 4'b0000) begin
         errors++; $display("FAIL rst_pulses: got %b want 0000", {bus.gnt0, bus.gnt1, bus.done0, bus.done1});
      end
      checks++;
      if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", bus.mem_addr); end
      checks++;
      if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", bus.mem_wdata); end
      checks++;
      if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", bus.rdata); end
      bus.req0 = 1'b0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      reset = 1'b0;
      tick();
      checks++;
      if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL rst_idle: got %b want 0", bus.mem_valid); end
   endtask

   task automatic test_single_read;
      bus.req0 = 1'b1;
      bus.addr0 = 32'h0000_0040;
      bus.we0 = 1'b0;
      tick();
      checks++;
      if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL rd_valid_lat: got %b want 1", bus.mem_valid); end
      checks++;
      if (bus.mem_addr !== 32'h40) begin errors++; $display("FAIL rd_addr: got %h want 00000040", bus.mem_addr); end
      checks++;
      if (bus.gnt0 !== 1'b0) begin errors++; $display("FAIL rd_early_gnt: got %b want 0", bus.gnt0); end
      tick();
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'hDEAD_BEEF;
      #1;
      checks++;
      if ({bus.gnt0, bus.done0, bus.done1} !== 3'b110) begin
         errors++; $display("FAIL rd_done: gnt0/done0/done1 got %b want 110", {bus.gnt0, bus.done0, bus.done1});
      end
      checks++;
      if (bus.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata: got %h want deadbeef", bus.rdata); end
      tick();
      bus.req0 = 1'b0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h0BAD_F00D;
      #1;
      checks++;
      if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL rd_idle: got %b want 0", bus.mem_valid); end
      checks++;
      if (bus.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_hold: got %h want deadbeef", bus.rdata); end
   endtask

   task automatic test_reset_mid;
      int d1;
      d1 = done1_cnt;
      bus.req1 = 1'b1;
      bus.addr1 = 32'h0000_0400;
      bus.we1 = 1'b0;
      tick();
      checks++;
      if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h400) begin
         errors++; $display("FAIL rm_busy1: valid=%b addr=%h want 1 00000400", bus.mem_valid, bus.mem_addr);
      end
      reset = 1'b1;
      bus.mem_ready = 1'b1;
      #1;
      checks++;
      if (bus.done1 !== 1'b0) begin errors++; $display("FAIL rm_done_in_rst: got %b want 0", bus.done1); end
      tick();
      checks++;
      if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b want 0", bus.mem_valid); end
      checks++;
      if (bus.mem_addr !== 32'h0 || bus.rdata !== 32'h0) begin
         errors++; $display("FAIL rm_clear: addr=%h rdata=%h want 0 0", bus.mem_addr, bus.rdata);
      end
      reset = 1'b0;
      bus.mem_ready = 1'b0;
      bus.req0 = 1'b1;
      bus.addr0 = 32'h0000_0500;
      tick();
      checks++;
      if (bus.mem_addr !== 32'h500) begin errors++; $display("FAIL rm_first_arb: addr got %h want 00000500", bus.mem_addr); end
      bus.mem_ready = 1'b1;
      #1;
      checks++;
      if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
         errors++; $display("FAIL rm_first_gnt: gnt0/gnt1 got %b want 10", {bus.gnt0, bus.gnt1});
      end
      tick();
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      bus.mem_ready = 1'b0;
      tick();
      checks++;
      if (done1_cnt != d1) begin errors++; $display("FAIL rm_no_done1: got %0d pulses want 0", done1_cnt - d1); end
   endtask

   task automatic test_write;
      int d1;
      d1 = done1_cnt;
      bus.req1 = 1'b1;
      bus.we1 = 1'b1;
      bus.addr1 = 32'h0000_0100;
      bus.wdata1 = 32'h1234_5678;
      tick();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus.mem_valid !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h100 ||
             bus.mem_wdata !== 32'h1234_5678 || bus.done1 !== 1'b0) begin
            errors++;
            $display("FAIL wr_hold[%0d]: valid=%b we=%b addr=%h wdata=%h done1=%b want 1 1 00000100 12345678 0",
                     i, bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.done1);
         end
         tick();
      end
      bus.mem_ready = 1'b1;
      #1;
      checks++;
      if (bus.done1 !== 1'b1 || bus.mem_we !== 1'b1) begin
         errors++; $display("FAIL wr_done: done1=%b we=%b want 1 1", bus.done1, bus.mem_we);
      end
      tick();
      bus.req1 = 1'b0;
      bus.we1 = 1'b0;
      bus.mem_ready = 1'b0;
      #1;
      checks++;
      if (bus.mem_we !== 1'b0 || bus.mem_valid !== 1'b0) begin
         errors++; $display("FAIL wr_idle_we: we=%b valid=%b want 0 0", bus.mem_we, bus.mem_valid);
      end
      tick();
      checks++;
      if (done1_cnt - d1 != 1) begin errors++; $display("FAIL wr_once: got %0d pulses want 1", done1_cnt - d1); end
   endtask

   task automatic test_no_preempt;
      bus.req0 = 1'b1;
      bus.addr0 = 32'h0000_0200;
      bus.we0 = 1'b0;
      tick();
      bus.req1 = 1'b1;
      bus.addr1 = 32'h0000_0300;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus.mem_addr !== 32'h200 || bus.gnt1 !== 1'b0 || bus.mem_valid !== 1'b1) begin
            errors++;
            $display("FAIL np_wait[%0d]: addr=%h gnt1=%b valid=%b want 00000200 0 1",
                     i, bus.mem_addr, bus.gnt1, bus.mem_valid);
         end
         tick();
      end
      bus.mem_ready = 1'b1;
      #1;
      checks++;
      if (bus.done0 !== 1'b1 || bus.gnt1 !== 1'b0 || bus.mem_addr !== 32'h200) begin
         errors++; $display("FAIL np_done0: done0=%b gnt1=%b addr=%h want 1 0 00000200", bus.done0, bus.gnt1, bus.mem_addr);
      end
      tick();
      bus.req0 = 1'b0;
      bus.mem_ready = 1'b0;
      #1;
      checks++;
      if (bus.mem_valid !== 1'b0 || bus.gnt1 !== 1'b0) begin
         errors++; $display("FAIL np_idle_gap: valid=%b gnt1=%b want 0 0", bus.mem_valid, bus.gnt1);
      end
      tick();
      checks++;
      if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h300) begin
         errors++; $display("FAIL np_busy1: valid=%b addr=%h want 1 00000300", bus.mem_valid, bus.mem_addr);
      end
      bus.mem_ready = 1'b1;
      #1;
      checks++;
      if (bus.gnt1 !== 1'b1) begin errors++; $display("FAIL np_gnt1: got %b want 1", bus.gnt1); end
      tick();
      bus.req1 = 1'b0;
      bus.mem_ready = 1'b0;
      tick();
   endtask

   task automatic test_contention;
      int exp_id;
      reset = 1'b1;
      bus.req0 = 1'b1;
      bus.req1 = 1'b1;
      bus.addr0 = 32'h10;
      bus.addr1 = 32'h20;
      bus.mem_ready = 1'b1;
      tick();
      tick();
      gnt_id.delete();
      gnt_cyc.delete();
      reset = 1'b0;
      repeat (8) tick();
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      bus.mem_ready = 1'b0;
      tick();
      checks++;
      if (gnt_id.size() != 4) begin
         errors++; $display("FAIL ct_count: got %0d grants want 4", gnt_id.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
`ifdef MEM_PORT_ARBITER_FIXED_PRIO_EN
            exp_id = 0;
`else
            exp_id = i % 2;
`endif
            checks++;
            if (gnt_id[i] != exp_id) begin
               errors++; $display("FAIL ct_order[%0d]: got %0d want %0d", i, gnt_id[i], exp_id);
            end
            if (i > 0) begin
               checks++;
               if (gnt_cyc[i] - gnt_cyc[i-1] != 2) begin
                  errors++; $display("FAIL ct_gap[%0d]: got %0d cycles want 2", i, gnt_cyc[i] - gnt_cyc[i-1]);
               end
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      bus.addr0 = '0;
      bus.addr1 = '0;
      bus.wdata0 = '0;
      bus.wdata1 = '0;
      bus.we0 = 1'b0;
      bus.we1 = 1'b0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      test_reset();
      test_single_read();
      test_reset_mid();
      test_write();
      test_no_preempt();
      test_contention();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
